mem_slot_arbiter: RTL and testbench
===================================

# mem_slot_arbiter

Shares the single DRAM bus between video, refresh, DMA, blitter and CPU on a slot-by-slot basis. It runs in the clk32 domain and consumes the one-cycle slot strobe produced by the clock generator (cycsel_en), one strobe per memory bus cycle. Each slot gets exactly one owner, chosen at the slot boundary. Slots alternate even/odd: even slots serve video and refresh, odd slots serve DMA, blitter and CPU, with starvation protection for the CPU.

## Interface
- REF_INTERVAL, 64: even slots between refresh requests (≥2).
- CPU_MAX_WAIT, 4: consecutive denied odd slots before the CPU is forced (1..15).
- clk32  in  1  system clock, 32 MHz.
- rst  in  1  reset, asynchronous, active-high.
- slot_start  in  1  one-clk32 pulse marking a slot boundary.
- vid_req  in  1  video fetch request, level.
- dma_req, blt_req, cpu_req  in  1 each  level requests, held until the matching ack.
- owner  out  3  current slot owner (owner_t).
- slot_odd  out  1  current slot parity.
- vid_ack, dma_ack, blt_ack, cpu_ack  out  1 each  one-cycle completion pulse.
- ref_miss  out  1  one-cycle pulse: refresh interval expired while refresh still pending.

## Operation
- owner encoding: NONE=0, VID=1, REF=2, DMA=3, BLT=4, CPU=5.
- Two states:
  - WAIT: after reset, until the first slot_start. owner=NONE.
  - RUN: every subsequent slot.
- On each clk32 edge with slot_start=1, three things happen in the same edge.
- Close the current slot:
  - If owner is a requester and its req is still 1, pulse its ack.
  - If the req is 0, no ack is issued (the request was abandoned).
- Toggle slot_odd. Reset value is 1, so the first slot is even.
- Arbitrate the new slot from the requests sampled this cycle:
  - Even slot: vid_req → VID; else ref_pending → REF; else dma_req → DMA; else NONE.
  - Odd slot: cpu_req and cpu_wait==CPU_MAX_WAIT → CPU; else DMA > BLT > CPU priority; else NONE.
- cpu_wait (4-bit), evaluated at each odd-slot arbitration:
  - Increments (saturating at CPU_MAX_WAIT) when cpu_req=1 and CPU is not granted.
  - Clears when CPU is granted or cpu_req=0.
  - Unchanged at even slots.
- Refresh:
  - ref_cnt counts even slots, wrapping at REF_INTERVAL-1.
  - On wrap, set ref_pending. If ref_pending is already 1, pulse ref_miss instead.
  - ref_pending clears when REF is granted.
  - If wrap and REF grant occur on the same edge, ref_pending stays 1 (new request) with no miss.
- Without slot_start, owner and all counters hold.

## Timing
- All outputs are registered.
- Owner, ack and slot_odd update on the edge where slot_start is sampled high. Latency is 1 clk32 from the strobe to the new owner.
- Acks are exactly 1 clk32 wide and coincide with the owner change.
- A requester sees its ack no earlier than one full slot after its grant.
- Reset values (any time, asynchronous):
  - owner=NONE, slot_odd=1, all acks=0, ref_miss=0.
  - cpu_wait=0, ref_cnt=0, ref_pending=0, state=WAIT.
- Reset mid-slot: the slot is dropped and no ack is issued. The first slot_start after release behaves as the first slot.
- A req dropping and slot_start in the same cycle: no ack, and the req is not eligible for the new slot.
- A req rising in the same cycle as slot_start: eligible immediately.
- Back-to-back slot_start (consecutive cycles) is legal. Each pulse is a full boundary.

## Configuration
- REFRESH_EN defined: refresh counter and REF owner present as described.
- REFRESH_EN undefined:
  - No ref_cnt or ref_pending; REF is never granted; ref_miss is tied 0.
  - Even slots go VID, then DMA, then NONE.
  - REF_INTERVAL is ignored.

## Structure
- Package mem_arb_pkg holds:
  - owner_t enum with OWN_NONE..OWN_CPU.
  - The state enum.
  - CPU_WAIT_W = 4.
- Sub-module refresh_timer (ref_cnt, ref_pending, ref_miss; inputs even_tick, ref_grant). Instantiated only under REFRESH_EN.

## Test plan
- Reset release, 4 slot_start pulses, no requests → owner NONE throughout; slot_odd sequence 0,1,0,1; no acks.
- vid_req and dma_req held high → even slots VID, odd slots DMA; vid_ack and dma_ack pulse at each boundary after their slot.
- dma_req and cpu_req held, CPU_MAX_WAIT=4 → odd owners DMA×4, then CPU, then DMA×4 again; cpu_ack 1 slot after the CPU grant.
- REFRESH_EN, REF_INTERVAL=4, vid_req held for 8 even slots then dropped → ref_miss pulses at the second wrap; first free even slot is REF, ref_pending cleared.
- blt_req granted, dropped mid-slot → no blt_ack; next odd slot NONE.
- rst asserted 3 cycles into a CPU slot → owner NONE immediately, cpu_ack never pulses; after release, first slot is even.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the DRAM slot arbiter: owner encoding, FSM state and
// the CPU starvation counter width.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_VID  = 3'd1,
    OWN_REF  = 3'd2,
    OWN_DMA  = 3'd3,
    OWN_BLT  = 3'd4,
    OWN_CPU  = 3'd5
  } owner_t;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CPU_WAIT_W = 4;

endpackage

// File: rtl/mem_slot_arbiter_refresh_timer.sv
// Refresh interval timer: counts even slots and raises a refresh request on
// each wrap, flagging a miss when the previous request was never served.
module refresh_timer #(
  parameter int REF_INTERVAL = 64
) (
  input  logic clk32,
  input  logic rst,
  input  logic even_tick,
  input  logic ref_grant,
  output logic ref_pending,
  output logic ref_miss
);

  localparam int CNT_W = $clog2(REF_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_pending_q, ref_pending_d;
  logic             ref_miss_q, ref_miss_d;
  logic             wrap;

  // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    ref_cnt_d     = ref_cnt_q;
    ref_pending_d = ref_pending_q;
    ref_miss_d    = 1'b0;
    wrap          = even_tick && (ref_cnt_q == CNT_LAST);

    if (even_tick) begin
      ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;
    end

    // A wrap on the grant edge re-arms the request instead of reporting a miss.
    if (wrap) begin
      ref_pending_d = 1'b1;
      ref_miss_d    = ref_pending_q && !ref_grant;
    end else if (ref_grant) begin
      ref_pending_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      ref_cnt_q     <= '0;
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_miss_q    <= ref_miss_d;
    end
  end

  assign ref_pending = ref_pending_q;
  assign ref_miss    = ref_miss_q;

endmodule

// File: rtl/mem_slot_arbiter.sv
// Slot-by-slot DRAM bus arbiter: even slots serve video/refresh, odd slots
// serve DMA/blitter/CPU with CPU starvation protection. Refresh under REFRESH_EN.
module mem_slot_arbiter
  import mem_arb_pkg::*;
#(
  parameter int REF_INTERVAL = 64,
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic       clk32,
  input  logic       rst,
  input  logic       slot_start,
  input  logic       vid_req,
  input  logic       dma_req,
  input  logic       blt_req,
  input  logic       cpu_req,
  output logic [2:0] owner,
  output logic       slot_odd,
  output logic       vid_ack,
  output logic       dma_ack,
  output logic       blt_ack,
  output logic       cpu_ack,
  output logic       ref_miss
);

  localparam logic [CPU_WAIT_W-1:0] WAIT_MAX = CPU_WAIT_W'(CPU_MAX_WAIT);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  slot_odd_q, slot_odd_d;
  logic [CPU_WAIT_W-1:0] cpu_wait_q, cpu_wait_d;
  logic                  vid_ack_q, vid_ack_d;
  logic                  dma_ack_q, dma_ack_d;
  logic                  blt_ack_q, blt_ack_d;
  logic                  cpu_ack_q, cpu_ack_d;
  logic                  ref_pending;
  logic                  even_tick;
  logic                  ref_grant;

  // slot_odd_q is the parity of the slot being closed, so 1 means the new slot is even.
  assign even_tick = slot_start && slot_odd_q;
  assign ref_grant = even_tick && (owner_d == OWN_REF);

`ifdef REFRESH_EN
  refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_refresh_timer (
    .clk32      (clk32),
    .rst        (rst),
    .even_tick  (even_tick),
    .ref_grant  (ref_grant),
    .ref_pending(ref_pending),
    .ref_miss   (ref_miss)
  );
`else
  logic unused_refresh;
  assign unused_refresh = ref_grant ^ (|REF_INTERVAL);
  assign ref_pending    = 1'b0;
  assign ref_miss       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    slot_odd_d = slot_odd_q;
    cpu_wait_d = cpu_wait_q;
    vid_ack_d  = 1'b0;
    dma_ack_d  = 1'b0;
    blt_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;

    if (slot_start) begin
      state_d    = ST_RUN;
      slot_odd_d = !slot_odd_q;

      // Close the outgoing slot; a request dropped by now is abandoned.
      if (state_q == ST_RUN) begin
        unique case (owner_q)
          OWN_VID: vid_ack_d = vid_req;
          OWN_DMA: dma_ack_d = dma_req;
          OWN_BLT: blt_ack_d = blt_req;
          OWN_CPU: cpu_ack_d = cpu_req;
          default: ;
        endcase
      end

      if (slot_odd_q) begin
        if (vid_req)          owner_d = OWN_VID;
        else if (ref_pending) owner_d = OWN_REF;
        else if (dma_req)     owner_d = OWN_DMA;
        else                  owner_d = OWN_NONE;
      end else begin
        if (cpu_req && (cpu_wait_q == WAIT_MAX)) owner_d = OWN_CPU;
        else if (dma_req)                        owner_d = OWN_DMA;
        else if (blt_req)                        owner_d = OWN_BLT;
        else if (cpu_req)                        owner_d = OWN_CPU;
        else                                     owner_d = OWN_NONE;

        if (!cpu_req || (owner_d == OWN_CPU)) begin
          cpu_wait_d = '0;
        end else if (cpu_wait_q != WAIT_MAX) begin
          cpu_wait_d = cpu_wait_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      state_q    <= ST_WAIT;
      owner_q    <= OWN_NONE;
      slot_odd_q <= 1'b1;
      cpu_wait_q <= '0;
      vid_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      blt_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      slot_odd_q <= slot_odd_d;
      cpu_wait_q <= cpu_wait_d;
      vid_ack_q  <= vid_ack_d;
      dma_ack_q  <= dma_ack_d;
      blt_ack_q  <= blt_ack_d;
      cpu_ack_q  <= cpu_ack_d;
    end
  end

  assign owner    = owner_q;
  assign slot_odd = slot_odd_q;
  assign vid_ack  = vid_ack_q;
  assign dma_ack  = dma_ack_q;
  assign blt_ack  = blt_ack_q;
  assign cpu_ack  = cpu_ack_q;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Directed bench for mem_slot_arbiter; the refresh scenario runs when REFRESH_EN
// is defined, the non-refresh scenarios otherwise.
module tb_mem_slot_arbiter;

  localparam logic [2:0] O_NONE = 3'd0;
  localparam logic [2:0] O_VID  = 3'd1;
  localparam logic [2:0] O_REF  = 3'd2;
  localparam logic [2:0] O_DMA  = 3'd3;
  localparam logic [2:0] O_BLT  = 3'd4;
  localparam logic [2:0] O_CPU  = 3'd5;

  logic       clk32 = 1'b0;
  logic       rst;
  logic       slot_start;
  logic       vid_req, dma_req, blt_req, cpu_req;
  logic [2:0] owner;
  logic       slot_odd;
  logic       vid_ack, dma_ack, blt_ack, cpu_ack;
  logic       ref_miss;
  logic [3:0] acks;

  int checks   = 0;
  int failures = 0;

  assign acks = {vid_ack, dma_ack, blt_ack, cpu_ack};

  always #5 clk32 = ~clk32;

  mem_slot_arbiter #(
    .REF_INTERVAL(4),
    .CPU_MAX_WAIT(4)
  ) dut (
    .clk32     (clk32),
    .rst       (rst),
    .slot_start(slot_start),
    .vid_req   (vid_req),
    .dma_req   (dma_req),
    .blt_req   (blt_req),
    .cpu_req   (cpu_req),
    .owner     (owner),
    .slot_odd  (slot_odd),
    .vid_ack   (vid_ack),
    .dma_ack   (dma_ack),
    .blt_ack   (blt_ack),
    .cpu_ack   (cpu_ack),
    .ref_miss  (ref_miss)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One slot boundary, then one idle cycle to confirm the ack is a single pulse.
  task automatic do_slot(input string tag, input logic [2:0] exp_owner, input logic exp_odd,
                         input logic [3:0] exp_ack, input logic exp_miss = 1'b0);
    slot_start = 1'b1;
    @(posedge clk32); #1;
    slot_start = 1'b0;
    check({tag, ".owner"}, 32'(owner), 32'(exp_owner));
    check({tag, ".odd"}, 32'(slot_odd), 32'(exp_odd));
    check({tag, ".ack"}, 32'(acks), 32'(exp_ack));
    check({tag, ".miss"}, 32'(ref_miss), 32'(exp_miss));
    @(posedge clk32); #1;
    check({tag, ".ack_width"}, 32'(acks), 32'd0);
    check({tag, ".miss_width"}, 32'(ref_miss), 32'd0);
    check({tag, ".owner_hold"}, 32'(owner), 32'(exp_owner));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    slot_start = 1'b0;
    vid_req    = 1'b0;
    dma_req    = 1'b0;
    blt_req    = 1'b0;
    cpu_req    = 1'b0;
    repeat (3) @(posedge clk32);
    #1;
    check("rst.owner", 32'(owner), 32'(O_NONE));
    check("rst.odd", 32'(slot_odd), 32'd1);
    check("rst.acks", 32'(acks), 32'd0);
    check("rst.miss", 32'(ref_miss), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk32);
    #1;
    check("wait.owner", 32'(owner), 32'(O_NONE));
    check("wait.odd", 32'(slot_odd), 32'd1);

`ifdef REFRESH_EN
    // REF_INTERVAL=4 with video hogging even slots: wrap at even 4, miss at even 8.
    vid_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      do_slot($sformatf("rf_even%0d", i), O_VID, 1'b0, 4'b0000, (i == 8));
      do_slot($sformatf("rf_odd%0d", i), O_NONE, 1'b1, 4'b1000);
    end
    vid_req = 1'b0;
    do_slot("rf_ref", O_REF, 1'b0, 4'b0000);
    do_slot("rf_after_ref", O_NONE, 1'b1, 4'b0000);
    do_slot("rf_cleared", O_NONE, 1'b0, 4'b0000);
`else
    // Idle slots: parity 0,1,0,1, nobody owns the bus.
    do_slot("idle0", O_NONE, 1'b0, 4'b0000);
    do_slot("idle1", O_NONE, 1'b1, 4'b0000);
    do_slot("idle2", O_NONE, 1'b0, 4'b0000);
    do_slot("idle3", O_NONE, 1'b1, 4'b0000);

    // Video on even, DMA on odd; acks land one slot after the grant.
    vid_req = 1'b1;
    dma_req = 1'b1;
    do_slot("vd0", O_VID, 1'b0, 4'b0000);
    do_slot("vd1", O_DMA, 1'b1, 4'b1000);
    do_slot("vd2", O_VID, 1'b0, 4'b0100);
    do_slot("vd3", O_DMA, 1'b1, 4'b1000);
    vid_req = 1'b0;
    dma_req = 1'b0;
    do_slot("vd_abandon", O_NONE, 1'b0, 4'b0000);

    // DMA vs CPU: CPU forced on the fifth contested odd slot (slots 9 and 19).
    dma_req = 1'b1;
    cpu_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      do_slot($sformatf("starve%0d", i),
              (i == 9 || i == 19) ? O_CPU : O_DMA,
              1'((i % 2) == 1),
              (i == 1) ? 4'b0000 : ((i == 10 || i == 20) ? 4'b0001 : 4'b0100));
    end
    dma_req = 1'b0;
    cpu_req = 1'b0;
    do_slot("starve_end", O_NONE, 1'b1, 4'b0000);

    // Blitter request abandoned mid-slot.
    blt_req = 1'b1;
    do_slot("blt_even", O_NONE, 1'b0, 4'b0000);
    do_slot("blt_grant", O_BLT, 1'b1, 4'b0000);
    @(posedge clk32); #1;
    blt_req = 1'b0;
    do_slot("blt_drop", O_NONE, 1'b0, 4'b0000);
    do_slot("blt_next_odd", O_NONE, 1'b1, 4'b0000);

    // Request rising together with the strobe is eligible at once.
    vid_req = 1'b1;
    do_slot("rise_vid", O_VID, 1'b0, 4'b0000);
    do_slot("rise_close", O_NONE, 1'b1, 4'b1000);
    vid_req = 1'b0;

    // Back-to-back strobes are two full boundaries.
    vid_req    = 1'b1;
    dma_req    = 1'b1;
    slot_start = 1'b1;
    @(posedge clk32); #1;
    check("b2b0.owner", 32'(owner), 32'(O_VID));
    check("b2b0.odd", 32'(slot_odd), 32'd0);
    check("b2b0.ack", 32'(acks), 32'd0);
    @(posedge clk32); #1;
    slot_start = 1'b0;
    check("b2b1.owner", 32'(owner), 32'(O_DMA));
    check("b2b1.odd", 32'(slot_odd), 32'd1);
    check("b2b1.ack", 32'(acks), 32'(4'b1000));
    @(posedge clk32); #1;
    check("b2b1.ack_width", 32'(acks), 32'd0);
    vid_req = 1'b0;
    dma_req = 1'b0;
    do_slot("b2b_end", O_NONE, 1'b0, 4'b0000);

    // Reset three cycles into a CPU slot drops it without an ack.
    cpu_req = 1'b1;
    do_slot("cpu_grant", O_CPU, 1'b1, 4'b0000);
    repeat (2) @(posedge clk32);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.owner", 32'(owner), 32'(O_NONE));
    check("midrst.odd", 32'(slot_odd), 32'd1);
    check("midrst.acks", 32'(acks), 32'd0);
    repeat (2) @(posedge clk32);
    #1;
    check("midrst.acks_hold", 32'(acks), 32'd0);
    rst = 1'b0;
    do_slot("post_rst_even", O_NONE, 1'b0, 4'b0000);
    do_slot("post_rst_cpu", O_CPU, 1'b1, 4'b0000);
    do_slot("post_rst_ack", O_NONE, 1'b0, 4'b0001);
    cpu_req = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
